// File: rtl/mem_arbiter.sv
// mem_arbiter: merges icache (client 0) and dcache (client 1) word reads and
// write-through writes onto one external memory port.
//   - Round-robin grant between the two clients, at most one read outstanding.
//   - Issue is a combinational pass-through in the acceptance cycle.
//   - Read data is broadcast to both clients; only the valid pulse is steered
//     to the client that owns the outstanding read.
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_cN_ren / i_cN_wen      client N read / write strobe
//   i_cN_addr / i_cN_wdata   client N word address / write data
//   o_cN_ready               client N request accepted this cycle
//   o_cN_rdata / o_cN_valid  client N read data / one-cycle data valid
//   i_mem_ready              memory can take a request this cycle
//   o_mem_addr/ren/wen/wdata forwarded request
//   i_mem_rdata/i_mem_valid  memory read response
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_c0_ren,
  input  logic          i_c0_wen,
  input  logic [AW-1:0] i_c0_addr,
  input  logic [DW-1:0] i_c0_wdata,
  output logic          o_c0_ready,
  output logic [DW-1:0] o_c0_rdata,
  output logic          o_c0_valid,
  input  logic          i_c1_ren,
  input  logic          i_c1_wen,
  input  logic [AW-1:0] i_c1_addr,
  input  logic [DW-1:0] i_c1_wdata,
  output logic          o_c1_ready,
  output logic [DW-1:0] o_c1_rdata,
  output logic          o_c1_valid,
  input  logic          i_mem_ready,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_ren,
  output logic          o_mem_wen,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_valid
);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;   // client owning the outstanding read
  logic   last_q, last_d;     // client granted on the most recent acceptance

  logic req0, req1, winner, win_ren, win_wen, accept, resp;

  // State register; pointer resets to 1 so client 0 wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Arbitration, forwarding, response steering and next state.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    o_c0_ready  = 1'b0;
    o_c1_ready  = 1'b0;
    o_c0_valid  = 1'b0;
    o_c1_valid  = 1'b0;
    o_c0_rdata  = '0;
    o_c1_rdata  = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;

    req0 = i_c0_ren | i_c0_wen;
    req1 = i_c1_ren | i_c1_wen;

    // On a tie the client not granted last wins.
    if (req0 && req1) winner = ~last_q;
    else              winner = req1;

    win_ren = winner ? i_c1_ren : i_c0_ren;
    win_wen = winner ? i_c1_wen : i_c0_wen;

    // A response cycle frees the read slot, so a new request may issue with it.
    accept = !i_rst && i_mem_ready && (req0 || req1) &&
             ((state_q == IDLE) || i_mem_valid);
    // i_mem_valid while IDLE is spurious and ignored.
    resp   = !i_rst && (state_q == WAIT_RD) && i_mem_valid;

    if (!i_rst) begin
      o_mem_addr  = i_c0_addr;
      o_mem_wdata = i_c0_wdata;
      o_c0_rdata  = i_mem_rdata;
      o_c1_rdata  = i_mem_rdata;
    end

    if (resp) begin
      o_c0_valid = ~owner_q;
      o_c1_valid = owner_q;
      state_d    = IDLE;
    end

    if (accept) begin
      o_mem_addr  = winner ? i_c1_addr  : i_c0_addr;
      o_mem_wdata = winner ? i_c1_wdata : i_c0_wdata;
      // ren+wen together is treated as a write only.
      o_mem_wen   = win_wen;
      o_mem_ren   = win_ren & ~win_wen;
      o_c0_ready  = ~winner;
      o_c1_ready  = winner;
      last_d      = winner;
      if (win_ren && !win_wen) begin
        state_d = WAIT_RD;
        owner_d = winner;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; read responses are checked against a
// scoreboard of (owner, data) entries pushed when each read is accepted.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_c0_ren, i_c0_wen, i_c1_ren, i_c1_wen;
  logic [AW-1:0] i_c0_addr, i_c1_addr;
  logic [DW-1:0] i_c0_wdata, i_c1_wdata;
  logic          o_c0_ready, o_c0_valid, o_c1_ready, o_c1_valid;
  logic [DW-1:0] o_c0_rdata, o_c1_rdata;
  logic          i_mem_ready, o_mem_ren, o_mem_wen, i_mem_valid;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata, i_mem_rdata;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_c0_ren(i_c0_ren), .i_c0_wen(i_c0_wen), .i_c0_addr(i_c0_addr),
    .i_c0_wdata(i_c0_wdata), .o_c0_ready(o_c0_ready), .o_c0_rdata(o_c0_rdata),
    .o_c0_valid(o_c0_valid),
    .i_c1_ren(i_c1_ren), .i_c1_wen(i_c1_wen), .i_c1_addr(i_c1_addr),
    .i_c1_wdata(i_c1_wdata), .o_c1_ready(o_c1_ready), .o_c1_rdata(o_c1_rdata),
    .o_c1_valid(o_c1_valid),
    .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
    .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs sampled at negedge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_in();
    i_c0_ren = 1'b0; i_c0_wen = 1'b0; i_c0_addr = '0; i_c0_wdata = '0;
    i_c1_ren = 1'b0; i_c1_wen = 1'b0; i_c1_addr = '0; i_c1_wdata = '0;
    i_mem_ready = 1'b1; i_mem_valid = 1'b0; i_mem_rdata = '0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  // Expect a read issue for client c at address a this cycle.
  task automatic chk_read_issue(input string tag, input logic c,
                                input logic [31:0] a, input logic [31:0] d);
    chk1({tag, "_rdy0"}, o_c0_ready, !c);
    chk1({tag, "_rdy1"}, o_c1_ready, c);
    chk1({tag, "_ren"}, o_mem_ren, 1'b1);
    chk1({tag, "_wen"}, o_mem_wen, 1'b0);
    chkw({tag, "_addr"}, o_mem_addr, a);
    sb.push_back('{owner: c, data: d});
  endtask

  // Expect no valid pulse on either client.
  task automatic chk_no_valid(input string tag);
    chk1({tag, "_v0"}, o_c0_valid, 1'b0);
    chk1({tag, "_v1"}, o_c1_valid, 1'b0);
  endtask

  // Check the response currently driven on the memory port against the scoreboard.
  task automatic chk_resp(input string tag);
    sb_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=response expected=empty_scoreboard", tag);
    end else begin
      e = sb.pop_front();
      chk1({tag, "_v0"}, o_c0_valid, !e.owner);
      chk1({tag, "_v1"}, o_c1_valid, e.owner);
      chkw({tag, "_rdata"}, e.owner ? o_c1_rdata : o_c0_rdata, e.data);
    end
  endtask

  initial begin
    clear_in();
    i_rst = 1'b1;
    // Outputs forced low during reset even with a request present.
    i_c0_ren = 1'b1; i_c0_addr = 32'h100;
    #3;
    chk1("rst_rdy0", o_c0_ready, 1'b0);
    chk1("rst_ren", o_mem_ren, 1'b0);
    chk_no_valid("rst");
    tick();
    i_rst = 1'b0;

    // Single c0 read, latency 3.
    settle();
    chk_read_issue("t1_issue", 1'b0, 32'h100, 32'hDEADBEEF);
    tick();
    i_c0_ren = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle(); chk_no_valid("t1_wait"); tick();
    end
    i_mem_valid = 1'b1; i_mem_rdata = 32'hDEADBEEF;
    settle(); chk_resp("t1_resp");
    tick();
    i_mem_valid = 1'b0;
    settle(); chk_no_valid("t1_after");
    tick();

    // Tie after reset: c0 first, c1 held until c0's response cycle.
    do_reset();
    i_c0_ren = 1'b1; i_c0_addr = 32'h200;
    i_c1_ren = 1'b1; i_c1_addr = 32'h300;
    settle(); chk_read_issue("t2_tie", 1'b0, 32'h200, 32'hA0A0_0001);
    tick();
    i_c0_ren = 1'b0;
    settle();
    chk1("t2_hold_rdy1", o_c1_ready, 1'b0);
    chk1("t2_hold_ren", o_mem_ren, 1'b0);
    tick();
    i_mem_valid = 1'b1; i_mem_rdata = 32'hA0A0_0001;
    settle();
    chk_resp("t2_resp0");
    chk_read_issue("t2_b2b", 1'b1, 32'h300, 32'hB0B0_0002);
    tick();
    i_c1_ren = 1'b0; i_mem_valid = 1'b0;
    settle(); chk_no_valid("t2_wait");
    tick();
    i_mem_valid = 1'b1; i_mem_rdata = 32'hB0B0_0002;
    settle(); chk_resp("t2_resp1");
    tick();
    i_mem_valid = 1'b0;
    // Last grant was c1, so the next tie goes to c0.
    i_c0_ren = 1'b1; i_c0_addr = 32'h500;
    i_c1_ren = 1'b1; i_c1_addr = 32'h600;
    settle(); chk_read_issue("t2_tie2", 1'b0, 32'h500, 32'h5555_0005);
    tick();
    i_c0_ren = 1'b0;
    i_mem_valid = 1'b1; i_mem_rdata = 32'h5555_0005;
    settle();
    chk_resp("t2_resp2");
    chk_read_issue("t2_c1b", 1'b1, 32'h600, 32'h6666_0006);
    tick();
    i_c1_ren = 1'b0; i_mem_rdata = 32'h6666_0006;
    settle(); chk_resp("t2_resp3");
    tick();
    i_mem_valid = 1'b0;

    // c1 write while IDLE.
    i_c1_wen = 1'b1; i_c1_addr = 32'h40; i_c1_wdata = 32'h12345678;
    settle();
    chk1("t3_wen", o_mem_wen, 1'b1);
    chk1("t3_ren", o_mem_ren, 1'b0);
    chk1("t3_rdy1", o_c1_ready, 1'b1);
    chkw("t3_addr", o_mem_addr, 32'h40);
    chkw("t3_wdata", o_mem_wdata, 32'h12345678);
    tick();
    i_c1_wen = 1'b0;
    // Still IDLE: a c0 read issues at once.
    i_c0_ren = 1'b1; i_c0_addr = 32'h180;
    settle(); chk_read_issue("t3_rd", 1'b0, 32'h180, 32'hCAFE_0180);
    tick();
    i_c0_ren = 1'b0;
    // Write held off during WAIT_RD until the response cycle.
    i_c1_wen = 1'b1; i_c1_addr = 32'h44; i_c1_wdata = 32'h9ABCDEF0;
    settle();
    chk1("t3_wblk_rdy1", o_c1_ready, 1'b0);
    chk1("t3_wblk_wen", o_mem_wen, 1'b0);
    tick();
    i_mem_valid = 1'b1; i_mem_rdata = 32'hCAFE_0180;
    settle();
    chk_resp("t3_resp");
    chk1("t3_wacc_rdy1", o_c1_ready, 1'b1);
    chk1("t3_wacc_wen", o_mem_wen, 1'b1);
    chkw("t3_wacc_wdata", o_mem_wdata, 32'h9ABCDEF0);
    tick();
    i_c1_wen = 1'b0; i_mem_valid = 1'b0;

    // Memory not ready for 4 cycles with c0 read held.
    i_mem_ready = 1'b0; i_c0_ren = 1'b1; i_c0_addr = 32'h700;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk1("t4_stall_rdy0", o_c0_ready, 1'b0);
      chk1("t4_stall_ren", o_mem_ren, 1'b0);
      tick();
    end
    i_mem_ready = 1'b1;
    settle(); chk_read_issue("t4_issue", 1'b0, 32'h700, 32'h7777_0007);
    tick();
    i_c0_ren = 1'b0;

    // Reset during WAIT_RD abandons the read; late valid is spurious.
    settle();
    i_rst = 1'b1; i_mem_valid = 1'b1; i_mem_rdata = 32'h7777_0007;
    #1;
    chk_no_valid("t5_inrst");
    sb.delete();
    tick();
    i_rst = 1'b0;
    settle(); chk_no_valid("t5_late");
    tick();
    i_mem_valid = 1'b0;
    i_c1_ren = 1'b1; i_c1_addr = 32'h800;
    settle(); chk_read_issue("t5_fresh", 1'b1, 32'h800, 32'h8888_0008);
    tick();
    i_c1_ren = 1'b0;
    i_mem_valid = 1'b1; i_mem_rdata = 32'h8888_0008;
    settle(); chk_resp("t5_resp");
    tick();
    i_mem_valid = 1'b0;

    // Illegal ren+wen on c0 is forwarded as a write only.
    i_c0_ren = 1'b1; i_c0_wen = 1'b1; i_c0_addr = 32'h900; i_c0_wdata = 32'h0BAD_F00D;
    settle();
    chk1("t6_wen", o_mem_wen, 1'b1);
    chk1("t6_ren", o_mem_ren, 1'b0);
    chk1("t6_rdy0", o_c0_ready, 1'b1);
    tick();
    i_c0_ren = 1'b0; i_c0_wen = 1'b0;
    // Still IDLE: a c1 write is accepted with no response pending.
    i_c1_wen = 1'b1; i_c1_addr = 32'h904; i_c1_wdata = 32'h1111_2222;
    settle();
    chk1("t6_idle_rdy1", o_c1_ready, 1'b1);
    chk1("t6_idle_wen", o_mem_wen, 1'b1);
    tick();
    clear_in();

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
